pc_sequencer: RTL and testbench

- Program-counter sequencer and run/halt controller for the single-cycle CPU.
- Owns the PC register and selects the next PC: sequential, jump, taken branch, or hold on HALT.
- Gates instruction commit through `instr_valid`. The datapath ANDs RegWrite/MemWrite with it.
- Provides a debug run/single-step handshake and a retired-instruction counter.

---
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer and run/halt controller for the single-cycle CPU.
// Owns the PC, picks the next PC (sequential, jump, taken branch, or hold on
// HALT), gates commit through instr_valid, and counts retired instructions.
module pc_sequencer #(
   parameter int                    PC_WIDTH  = 8,
   parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
   parameter int                    CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run_req,
   input  logic                 step_req,
   input  logic                 clear_halt,
   input  logic                 halt,
   input  logic                 jump,
   input  logic                 branch,
   input  logic                 branch_cond,
   input  logic [PC_WIDTH-1:0]  jump_target,
   input  logic [PC_WIDTH-1:0]  branch_offset,
   output logic [PC_WIDTH-1:0]  pc,
   output logic [PC_WIDTH-1:0]  pc_plus1,
   output logic                 instr_valid,
   output logic                 halted,
   output logic [1:0]           state,
   output logic [CNT_WIDTH-1:0] retired_count
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [PC_WIDTH-1:0]    pc_q;
   logic [PC_WIDTH-1:0]    pc_d;
   logic [PC_WIDTH-1:0]    pc_inc;
   logic [PC_WIDTH-1:0]    next_pc;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic                   commit;

   // Only RUN and STEP let the current instruction take effect.
   assign commit = (state_q == RUN) || (state_q == STEP);

   // pc+1 wraps naturally at the PC width; it doubles as the JUMPL link value.
   assign pc_inc = pc_q + PC_WIDTH'(1);

   // Next-PC selection: halt holds, then jump, then taken branch, else sequential.
   always_comb begin
      next_pc = pc_inc;
      if (halt) begin
         next_pc = pc_q;
      end else if (jump) begin
         next_pc = jump_target;
      end else if (branch && branch_cond) begin
         next_pc = pc_inc + branch_offset;
      end
   end

   // Run/step/halt controller; run_req outranks step_req, halt outranks a falling run_req.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (run_req) begin
               state_d = RUN;
            end else if (step_req) begin
               state_d = STEP;
            end
         end
         RUN: begin
            if (halt) begin
               state_d = HALTED;
            end else if (!run_req) begin
               state_d = IDLE;
            end
         end
         STEP: begin
            if (halt) begin
               state_d = HALTED;
            end else begin
               state_d = IDLE;
            end
         end
         HALTED: begin
            if (clear_halt) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // PC advances only on committing cycles; the counter saturates instead of wrapping.
   always_comb begin
      pc_d  = pc_q;
      cnt_d = cnt_q;
      if (commit) begin
         pc_d = next_pc;
         if (!halt && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // State, PC and retired counter registers, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc            = pc_q;
   assign pc_plus1      = pc_inc;
   assign instr_valid   = commit;
   assign halted        = (state_q == HALTED);
   assign state         = state_q;
   assign retired_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. A second instance with a
// 4-bit retired counter shares the stimulus to exercise counter saturation.
module tb_pc_sequencer;

   logic        clk;
   logic        rst;
   logic        run_req;
   logic        step_req;
   logic        clear_halt;
   logic        halt;
   logic        jump;
   logic        branch;
   logic        branch_cond;
   logic [7:0]  jump_target;
   logic [7:0]  branch_offset;

   logic [7:0]  pc;
   logic [7:0]  pc_plus1;
   logic        instr_valid;
   logic        halted;
   logic [1:0]  state;
   logic [15:0] retired_count;

   logic [7:0]  pc4;
   logic [7:0]  pc_plus1_4;
   logic        instr_valid4;
   logic        halted4;
   logic [1:0]  state4;
   logic [3:0]  retired_count4;

   int n_checks;
   int n_fails;

   pc_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
      .clear_halt(clear_halt), .halt(halt), .jump(jump), .branch(branch),
      .branch_cond(branch_cond), .jump_target(jump_target),
      .branch_offset(branch_offset), .pc(pc), .pc_plus1(pc_plus1),
      .instr_valid(instr_valid), .halted(halted), .state(state),
      .retired_count(retired_count)
   );

   pc_sequencer #(.PC_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req),
      .clear_halt(clear_halt), .halt(halt), .jump(jump), .branch(branch),
      .branch_cond(branch_cond), .jump_target(jump_target),
      .branch_offset(branch_offset), .pc(pc4), .pc_plus1(pc_plus1_4),
      .instr_valid(instr_valid4), .halted(halted4), .state(state4),
      .retired_count(retired_count4)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance past the next rising edge; inputs are driven and outputs sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      halt        = 1'b0;
      jump        = 1'b0;
      branch      = 1'b0;
      branch_cond = 1'b0;
      clear_halt  = 1'b0;
      step_req    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      run_req = 1'b0;
      clear_ctrl();
      jump_target   = 8'h00;
      branch_offset = 8'h00;
      #1;
      n_checks++;
      if (pc !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 8'h00); end
      n_checks++;
      if (state !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_state: got %b expected %b", state, 2'b00); end
      n_checks++;
      if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
      n_checks++;
      if (halted !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
      n_checks++;
      if (retired_count !== 16'd0) begin n_fails++; $display("[TB] FAIL reset_count: got %0d expected 0", retired_count); end
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_checks++;
      if (state !== 2'b00 || pc !== 8'h00) begin n_fails++; $display("[TB] FAIL idle_after_reset: got state %b pc %h expected 00/00", state, pc); end
   endtask

   task automatic test_sequential();
      run_req = 1'b1;
      tick();
      n_checks++;
      if (state !== 2'b01 || pc !== 8'h00 || instr_valid !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL run_entry: got state %b pc %h valid %b expected 01/00/1", state, pc, instr_valid);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if (pc !== 8'(i) || retired_count !== 16'(i)) begin
            n_fails++;
            $display("[TB] FAIL seq_step%0d: got pc %h count %0d expected %h/%0d", i, pc, retired_count, 8'(i), i);
         end
      end
      n_checks++;
      if (state !== 2'b01) begin n_fails++; $display("[TB] FAIL seq_state: got %b expected 01", state); end
   endtask

   task automatic test_jump_branch();
      logic [7:0] exp_pc [5];
      exp_pc[0] = 8'h10;
      exp_pc[1] = 8'h40;
      exp_pc[2] = 8'h3F;
      exp_pc[3] = 8'h40;
      exp_pc[4] = 8'h41;
      for (int i = 0; i < 5; i++) begin
         clear_ctrl();
         case (i)
            0: begin jump = 1'b1; jump_target = 8'h10; end
            1: begin jump = 1'b1; jump_target = 8'h40; end
            2: begin branch = 1'b1; branch_cond = 1'b1; branch_offset = 8'hFE; end
            3: begin jump = 1'b1; jump_target = 8'h40; end
            default: begin branch = 1'b1; branch_cond = 1'b0; branch_offset = 8'hFE; end
         endcase
         tick();
         n_checks++;
         if (pc !== exp_pc[i]) begin
            n_fails++;
            $display("[TB] FAIL jump_branch%0d: got pc %h expected %h", i, pc, exp_pc[i]);
         end
      end
      clear_ctrl();
      n_checks++;
      if (retired_count !== 16'd9) begin n_fails++; $display("[TB] FAIL jump_branch_count: got %0d expected 9", retired_count); end
   endtask

   task automatic test_wrap();
      jump = 1'b1;
      jump_target = 8'hFF;
      tick();
      jump = 1'b0;
      #1;
      n_checks++;
      if (pc !== 8'hFF || pc_plus1 !== 8'h00) begin
         n_fails++;
         $display("[TB] FAIL wrap_plus1: got pc %h pc_plus1 %h expected ff/00", pc, pc_plus1);
      end
      tick();
      n_checks++;
      if (pc !== 8'h00) begin n_fails++; $display("[TB] FAIL wrap_pc: got %h expected 00", pc); end
   endtask

   task automatic test_halt();
      jump = 1'b1;
      jump_target = 8'h22;
      tick();
      // HALT together with a jump and a falling run_req: halt must win.
      halt = 1'b1;
      jump = 1'b1;
      jump_target = 8'h40;
      run_req = 1'b0;
      tick();
      clear_ctrl();
      n_checks++;
      if (state !== 2'b11 || halted !== 1'b1) begin n_fails++; $display("[TB] FAIL halt_state: got %b halted %b expected 11/1", state, halted); end
      n_checks++;
      if (pc !== 8'h22) begin n_fails++; $display("[TB] FAIL halt_pc: got %h expected 22", pc); end
      n_checks++;
      if (retired_count !== 16'd12) begin n_fails++; $display("[TB] FAIL halt_count: got %0d expected 12", retired_count); end
      n_checks++;
      if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL halt_valid: got %b expected 0", instr_valid); end
      // run and step requests are ignored while halted.
      run_req = 1'b1;
      step_req = 1'b1;
      tick();
      run_req = 1'b0;
      step_req = 1'b0;
      n_checks++;
      if (state !== 2'b11 || pc !== 8'h22) begin n_fails++; $display("[TB] FAIL halt_sticky: got state %b pc %h expected 11/22", state, pc); end
      clear_halt = 1'b1;
      tick();
      clear_halt = 1'b0;
      n_checks++;
      if (state !== 2'b00 || pc !== 8'h22 || halted !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL clear_halt: got state %b pc %h halted %b expected 00/22/0", state, pc, halted);
      end
   endtask

   task automatic test_step();
      int valid_cycles;
      // Reach pc=0x05 in IDLE: one run cycle that jumps while run_req drops.
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      jump = 1'b1;
      jump_target = 8'h05;
      tick();
      jump = 1'b0;
      n_checks++;
      if (state !== 2'b00 || pc !== 8'h05 || retired_count !== 16'd13) begin
         n_fails++;
         $display("[TB] FAIL run_stop: got state %b pc %h count %0d expected 00/05/13", state, pc, retired_count);
      end
      valid_cycles = 0;
      for (int s = 0; s < 3; s++) begin
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         if (instr_valid === 1'b1) valid_cycles++;
         tick();
         if (instr_valid === 1'b1) valid_cycles++;
         tick();
         if (instr_valid === 1'b1) valid_cycles++;
      end
      n_checks++;
      if (valid_cycles != 3) begin n_fails++; $display("[TB] FAIL step_valid_cycles: got %0d expected 3", valid_cycles); end
      n_checks++;
      if (pc !== 8'h08) begin n_fails++; $display("[TB] FAIL step_pc: got %h expected 08", pc); end
      n_checks++;
      if (retired_count !== 16'd16) begin n_fails++; $display("[TB] FAIL step_count: got %0d expected 16", retired_count); end
   endtask

   task automatic test_async_reset();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      n_checks++;
      if (state !== 2'b10) begin n_fails++; $display("[TB] FAIL step_entry: got %b expected 10", state); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (pc !== 8'h00 || state !== 2'b00 || retired_count !== 16'd0 || instr_valid !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL async_reset: got pc %h state %b count %0d valid %b expected 00/00/0/0", pc, state, retired_count, instr_valid);
      end
      #2;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_saturation();
      run_req = 1'b1;
      tick();
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            n_checks++;
            if (retired_count4 !== 4'd14) begin n_fails++; $display("[TB] FAIL sat_14: got %0d expected 14", retired_count4); end
         end
         if (i == 15) begin
            n_checks++;
            if (retired_count4 !== 4'd15) begin n_fails++; $display("[TB] FAIL sat_15: got %0d expected 15", retired_count4); end
         end
      end
      n_checks++;
      if (retired_count4 !== 4'd15) begin n_fails++; $display("[TB] FAIL sat_20: got %0d expected 15", retired_count4); end
      n_checks++;
      if (retired_count !== 16'd20) begin n_fails++; $display("[TB] FAIL wide_count_20: got %0d expected 20", retired_count); end
      n_checks++;
      if (pc4 !== 8'h14 || pc_plus1_4 !== 8'h15 || state4 !== 2'b01 || instr_valid4 !== 1'b1 || halted4 !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL sat_core: got pc %h plus1 %h state %b valid %b halted %b expected 14/15/01/1/0",
                  pc4, pc_plus1_4, state4, instr_valid4, halted4);
      end
      run_req = 1'b0;
      tick();
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      n_checks = 0;
      n_fails  = 0;
      test_reset();
      test_sequential();
      test_jump_branch();
      test_wrap();
      test_halt();
      test_step();
      test_async_reset();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
